// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers: state encoding, size limit and a
// constant-foldable clog2 used to size index ports.
package arb_pkg;

  localparam int unsigned ARB_MAX_N = 32;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Minimum bits to hold 0..v-1; evaluated at elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_hs_if.sv
// Request/grant/handshake bundle between requesters, arbiter and resource.
// The lock input exists only when RR_ARBITER_LOCK_EN is defined.
interface rr_arbiter_hs_if
  import arb_pkg::*;
#(
  parameter int unsigned N = 4
);
  localparam int unsigned IDXW = clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
`ifdef RR_ARBITER_LOCK_EN
  logic            lock;
`endif

  // Arbiter side.
  modport master (
    input  req,
    input  out_ready,
`ifdef RR_ARBITER_LOCK_EN
    input  lock,
`endif
    output gnt,
    output gnt_idx,
    output out_valid,
    output busy
  );

  // Requester/resource side.
  modport slave (
    output req,
    output out_ready,
`ifdef RR_ARBITER_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  gnt_idx,
    input  out_valid,
    input  busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req_masked searching
// from ptr upward with wrap at N-1, returned as one-hot and binary index.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned IDXW = clog2(N)
) (
  input  logic [N-1:0]    req_masked,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  localparam int unsigned SW = IDXW + 1;

  logic [2*N-1:0]  dbl_c;
  logic [N-1:0]    rot_c;
  logic [IDXW-1:0] off_c;
  logic [SW-1:0]   sum_c;

  // Rotating a doubled vector puts requester ptr at bit 0 for any N.
  assign dbl_c = {req_masked, req_masked};
  assign rot_c = N'(dbl_c >> ptr);

  always_comb begin
    off_c = '0;
    any   = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot_c[i]) begin
        off_c = IDXW'(i);
        any   = 1'b1;
      end
    end
    sum_c = {1'b0, ptr} + {1'b0, off_c};
    if (sum_c >= SW'(N)) sum_c = sum_c - SW'(N);
    idx    = IDXW'(sum_c);
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter_hs.sv
// Round-robin arbiter with registered one-hot grant and valid/ready handshake.
// Define RR_ARBITER_LOCK_EN to add a lock input that re-grants the same requester.
module rr_arbiter_hs
  import arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           reset,
  rr_arbiter_hs_if.master bus
);
  localparam int unsigned IDXW = clog2(N);

  arb_state_e      state_q;
  logic [N-1:0]    gnt_q;
  logic [IDXW-1:0] gnt_idx_q;
  logic [IDXW-1:0] ptr_q;
  logic            out_valid_q;

  logic            hs_c;
  logic [IDXW-1:0] nxt_ptr_c;
  logic [IDXW-1:0] sel_ptr_c;
  logic [N-1:0]    sel_req_c;
  logic [N-1:0]    pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
`ifdef RR_ARBITER_LOCK_EN
  logic            lock_hold_c;
`endif

  // Selection inputs: on a handshake the served line is masked and ptr advances.
  always_comb begin
    hs_c      = out_valid_q && bus.out_ready;
    nxt_ptr_c = (gnt_idx_q == IDXW'(N - 1)) ? '0 : gnt_idx_q + IDXW'(1);
    sel_req_c = bus.req;
    sel_ptr_c = ptr_q;
`ifdef RR_ARBITER_LOCK_EN
    lock_hold_c = 1'b0;
`endif
    if (hs_c) begin
      sel_req_c = bus.req & ~gnt_q;
`ifdef RR_ARBITER_LOCK_EN
      lock_hold_c = bus.lock && (|(bus.req & gnt_q));
      if (!bus.lock) sel_ptr_c = nxt_ptr_c;
`else
      sel_ptr_c = nxt_ptr_c;
`endif
    end
  end

  rr_pick #(.N(N)) u_pick (
    .req_masked (sel_req_c),
    .ptr        (sel_ptr_c),
    .onehot     (pick_onehot),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_q       <= pick_onehot;
            gnt_idx_q   <= pick_idx;
            out_valid_q <= 1'b1;
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (hs_c) begin
            ptr_q <= sel_ptr_c;
`ifdef RR_ARBITER_LOCK_EN
            if (lock_hold_c) state_q <= ARB_GRANT;
            else
`endif
            if (pick_any) begin
              gnt_q       <= pick_onehot;
              gnt_idx_q   <= pick_idx;
              out_valid_q <= 1'b1;
            end else begin
              gnt_q       <= '0;
              gnt_idx_q   <= '0;
              out_valid_q <= 1'b0;
              state_q     <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = out_valid_q;

endmodule

// File: tb/tb_rr_arbiter_hs.sv
// Self-checking bench for rr_arbiter_hs: N=4 and N=3 instances driven from a
// vector table through a scoreboard queue, plus a hand-written async reset case.
module tb_rr_arbiter_hs;

  logic clk  = 1'b0;
  logic rst4 = 1'b1;
  logic rst3 = 1'b1;

  rr_arbiter_hs_if #(.N(4)) b4 ();
  rr_arbiter_hs_if #(.N(3)) b3 ();

  rr_arbiter_hs #(.N(4)) dut4 (.clk(clk), .reset(rst4), .bus(b4));
  rr_arbiter_hs #(.N(3)) dut3 (.clk(clk), .reset(rst3), .bus(b3));

  always #5 clk = ~clk;

  // A granted requester must keep its request up until the handshake.
  a_hold4: assert property (@(posedge clk) disable iff (rst4)
                            b4.out_valid |-> (|(b4.req & b4.gnt)))
    else $error("FAIL req_withdrawn dut4 gnt=%b req=%b", b4.gnt, b4.req);
  a_hold3: assert property (@(posedge clk) disable iff (rst3)
                            b3.out_valid |-> (|(b3.req & b3.gnt)))
    else $error("FAIL req_withdrawn dut3 gnt=%b req=%b", b3.gnt, b3.req);

  typedef struct {
    int         d;
    logic       rs;
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    logic [3:0] eg;
    logic [1:0] ei;
  } vec_t;

  typedef struct {
    int         d;
    int         row;
    logic       ev;
    logic [3:0] eg;
    logic [1:0] ei;
  } exp_t;

  vec_t tab[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input int d, input logic rs, input logic [3:0] req, input logic rdy,
                     input logic ev, input logic [3:0] eg, input logic [1:0] ei);
    vec_t v;
    v.d = d; v.rs = rs; v.req = req; v.rdy = rdy;
    v.ev = ev; v.eg = eg; v.ei = ei;
    tab.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t       e;
    logic       v;
    logic       b;
    logic [3:0] g;
    logic [1:0] i;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sbq.pop_front();
    if (e.d == 4) begin
      v = b4.out_valid; b = b4.busy; g = b4.gnt; i = b4.gnt_idx;
    end else begin
      v = b3.out_valid; b = b3.busy; g = {1'b0, b3.gnt}; i = b3.gnt_idx;
    end
    chk("out_valid", e.row, int'(v), int'(e.ev));
    chk("busy",      e.row, int'(b), int'(e.ev));
    chk("gnt",       e.row, int'(g), int'(e.eg));
    chk("gnt_idx",   e.row, int'(i), int'(e.ei));
  endtask

  vec_t cur;
  exp_t e;

  initial begin
    b4.req = '0; b4.out_ready = 1'b0;
    b3.req = '0; b3.out_ready = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
    b4.lock = 1'b0;
    b3.lock = 1'b0;
`endif

    // Idle after reset.
    add(4, 1, 4'b0000, 0, 0, 4'b0000, 0);
    for (int k = 0; k < 5; k++) add(4, 0, 4'b0000, 0, 0, 4'b0000, 0);
    // All requesting, ready held: 0,1,2,3,0 with no bubble.
    add(4, 0, 4'b1111, 1, 1, 4'b0001, 0);
    add(4, 0, 4'b1111, 1, 1, 4'b0010, 1);
    add(4, 0, 4'b1111, 1, 1, 4'b0100, 2);
    add(4, 0, 4'b1111, 1, 1, 4'b1000, 3);
    add(4, 0, 4'b1111, 1, 1, 4'b0001, 0);
    // Back-pressure: grant held stable, then next grant is requester 3.
    add(4, 1, 4'b1111, 0, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++) add(4, 0, 4'b1010, 0, 1, 4'b0010, 1);
    add(4, 0, 4'b1010, 1, 1, 4'b1000, 3);
    add(4, 0, 4'b1000, 1, 0, 4'b0000, 0);
    add(4, 0, 4'b0000, 1, 0, 4'b0000, 0);
    // Single requester: one grant every other cycle.
    add(4, 1, 4'b0000, 0, 0, 4'b0000, 0);
    add(4, 0, 4'b0100, 1, 1, 4'b0100, 2);
    add(4, 0, 4'b0100, 1, 0, 4'b0000, 0);
    add(4, 0, 4'b0100, 1, 1, 4'b0100, 2);
    add(4, 0, 4'b0100, 1, 0, 4'b0000, 0);
    // New requests during GRANT only matter at the handshake.
    add(4, 1, 4'b0000, 0, 0, 4'b0000, 0);
    add(4, 0, 4'b0010, 0, 1, 4'b0010, 1);
    add(4, 0, 4'b1011, 0, 1, 4'b0010, 1);
    add(4, 0, 4'b1011, 1, 1, 4'b1000, 3);
    add(4, 0, 4'b1001, 1, 1, 4'b0001, 0);
    add(4, 0, 4'b0001, 1, 0, 4'b0000, 0);
    add(4, 0, 4'b0000, 0, 0, 4'b0000, 0);
    // N=3: pointer wraps from 2 back to 0.
    add(3, 1, 4'b0000, 0, 0, 4'b0000, 0);
    add(3, 0, 4'b0111, 1, 1, 4'b0001, 0);
    add(3, 0, 4'b0111, 1, 1, 4'b0010, 1);
    add(3, 0, 4'b0111, 1, 1, 4'b0100, 2);
    add(3, 0, 4'b0111, 1, 1, 4'b0001, 0);
    add(3, 0, 4'b0111, 1, 1, 4'b0010, 1);
    add(3, 1, 4'b0000, 0, 0, 4'b0000, 0);

    // Reset asserted mid-GRANT clears outputs without a clock edge.
    @(negedge clk);
    rst4 = 1'b0; b4.req = 4'b0100; b4.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_gnt",   -1, int'(b4.gnt),       4);
    chk("rst_pre_valid", -1, int'(b4.out_valid), 1);
    #2 rst4 = 1'b1;
    #1;
    chk("rst_async_gnt",   -1, int'(b4.gnt),       0);
    chk("rst_async_valid", -1, int'(b4.out_valid), 0);
    chk("rst_async_idx",   -1, int'(b4.gnt_idx),   0);
    @(negedge clk);
    rst4 = 1'b0;
    @(posedge clk); #1;
    chk("rst_post_gnt",   -1, int'(b4.gnt),       4);
    chk("rst_post_idx",   -1, int'(b4.gnt_idx),   2);
    chk("rst_post_valid", -1, int'(b4.out_valid), 1);

    for (int k = 0; k < tab.size(); k++) begin
      cur = tab[k];
      @(negedge clk);
      if (cur.d == 4) begin
        rst4 = cur.rs; b4.req = cur.req; b4.out_ready = cur.rdy;
      end else begin
        rst3 = cur.rs; b3.req = cur.req[2:0]; b3.out_ready = cur.rdy;
      end
      e.d = cur.d; e.row = k; e.ev = cur.ev; e.eg = cur.eg; e.ei = cur.ei;
      sbq.push_back(e);
      @(posedge clk); #1;
      check_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_hs.md
Name: rr_arbiter_hs

Overview:
Parametrised round-robin arbiter: N requesters, registered one-hot grant plus binary index, and a valid/ready handshake toward the shared resource. It generalises the combinational first-one select/encode used by the TLB and cache-miss paths into a fair, stateful arbiter. Used for refill-bus, writeback-port and AXI read-channel sharing.

Parameters:
N, 4, number of requesters; 2..32; need not be a power of two
IDXW, $clog2(N), width of gnt_idx (derived; do not override)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
req  input  N  level request per requester
gnt  output  N  registered one-hot grant; all-zero when out_valid=0
gnt_idx  output  IDXW  binary index of the granted requester
out_valid  output  1  grant valid toward the resource
out_ready  input  1  resource accepts the granted transaction
busy  output  1  equals out_valid; for pipeline stall logic

Behaviour:
- Reset (asynchronous assert, synchronous release): gnt=0, gnt_idx=0, out_valid=0, ptr=0, state IDLE.
- ptr (IDXW bits) is the highest-priority index. Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The winner is the first set bit in that order.
- IDLE: if |req, on the next edge load gnt/gnt_idx with the winner, set out_valid=1, and go to GRANT. Request-to-grant latency is 1 cycle. If req=0, stay in IDLE with outputs at zero.
- GRANT: gnt, gnt_idx and out_valid hold stable until out_valid&&out_ready. This is a handshake cycle.
- On a handshake edge:
  - ptr <= gnt_idx+1, wrapping N-1 -> 0 (also for non-power-of-2 N).
  - The served bit is masked from req for the selection made at this edge.
  - If any other request is pending, load the new winner (using the updated ptr) and stay in GRANT with out_valid=1. This gives back-to-back grants with no bubble.
  - Otherwise go to IDLE with out_valid=0 and gnt=0.
- Served requester: drops req in the cycle after its handshake. If it is still high at the next selection, it competes normally at lowest priority.
- Request withdrawal while granted is a protocol violation. The grant is still held until the handshake; simulation assertion in the bench.
- req changes on non-granted lines during GRANT have no effect on outputs until the handshake.
- Single requester: served every handshake; with req held it is re-granted after a masked pass. So its throughput is one grant per two cycles.
- Fairness: with all N requests held, each requester is granted exactly once per N handshakes.
- Reset mid-GRANT: outputs clear immediately. The pending transaction is dropped; the resource must also be reset.
- gnt is always one-hot or zero. gnt_idx equals the encode of gnt whenever out_valid=1.

Optional Feature:
RR_ARBITER_LOCK_EN
- Defined: adds input lock (1 bit). If lock=1 on a handshake edge, ptr is unchanged and the same requester is re-granted (no mask) if its req is still high. Used for multi-beat bursts.
- Not defined: port is absent; behaviour is as above.

Decomposition:
- Shared package arb_pkg: constant ARB_MAX_N=32; state enum {ARB_IDLE, ARB_GRANT}; clog2 helper function.
- One sub-module, rr_pick:
  - Combinational, parametrised by N.
  - Inputs: req_masked[N-1:0], ptr.
  - Outputs: onehot[N-1:0], idx, any.
  - Implementation: double-width rotate, first-one select, mod-N index.

Test Plan:
1. After reset, req=4'b0000 for 5 cycles -> out_valid=0, gnt=0, gnt_idx=0 throughout.
2. N=4, req=4'b1111 held, out_ready=1 -> gnt_idx sequence 0,1,2,3,0 on consecutive cycles starting 1 cycle after req. There are no bubbles.
3. req=4'b1010, out_ready=0 for 3 cycles then 1 -> gnt=4'b0010 held stable all 4 cycles. Next grant is gnt=4'b1000, gnt_idx=3.
4. N=3, ptr reaches 2, req=3'b111 -> after idx 2 the next grant is idx 0 (wrap at N-1).
5. Only req[2]=1 held, out_ready=1 -> grants idx 2 every other cycle, with out_valid toggling 1,0,1.
6. Assert reset in GRANT with gnt=4'b0100 -> gnt=0 and out_valid=0 in the same cycle, without waiting for a clock edge. After release with req=4'b0100, granted again after 1 cycle.
